// File: rtl/spi_mem_arbiter_if.sv
// Signal bundle between the CPU fetch/data ports, the SPI memory interface and
// the arbiter. The master side drives requests and memory responses. The slave
// side (the arbiter) drives grants, completions and status.
// Handshake: every *_req, mem_request, mem_special, mem_ready, mem_write_complete,
// if_ready, d_done and timeout_err is a one-cycle pulse sampled on the rising clk
// edge. Request operands are valid only in the cycle of their request pulse.
// Read data is valid in the cycle of its completion pulse. mem_request_type,
// mem_address and mem_write_data stay stable from the mem_request pulse until the
// transaction completes.
interface spi_mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_data;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        store_req;
  logic        mem_request;
  logic        mem_request_type;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic        mem_special;
  logic [15:0] mem_data_out;
  logic        mem_ready;
  logic        mem_write_complete;
  logic        busy;
  logic        timeout_err;
  logic [1:0]  state_dbg;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, store_req,
           mem_data_out, mem_ready, mem_write_complete,
    input  if_data, if_ready, d_rdata, d_done, mem_request, mem_request_type,
           mem_address, mem_write_data, mem_special, busy, timeout_err, state_dbg
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, store_req,
           mem_data_out, mem_ready, mem_write_complete,
    output if_data, if_ready, d_rdata, d_done, mem_request, mem_request_type,
           mem_address, mem_write_data, mem_special, busy, timeout_err, state_dbg
  );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI memory interface between the instruction-fetch port, the data
// port and the SRAM store operation. Pulsed requests are latched, one transaction
// is granted at a time (fetch/data round-robin, store lowest), completions are
// routed back to the owner, and a watchdog aborts hung transfers.
module spi_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 4000,
  parameter int TIMEOUT_W      = 12
) (
  input logic              clk,
  input logic              reset,
  spi_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT      = 2'd2,
    S_STORE_GAP = 2'd3
  } state_t;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;
  // The watchdog counts completed WAIT cycles; the abort fires on the cycle that
  // would bring the count to TIMEOUT_CYCLES.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [TIMEOUT_W-1:0] wd;
  logic                 last_grant;
  logic                 owner;
  logic                 f_pend;
  logic [15:0]          f_addr;
  logic                 d_pend;
  logic                 d_we_q;
  logic [15:0]          d_addr_q;
  logic [15:0]          d_wdata_q;
  logic                 s_pend;
  logic                 done_ok;
  logic                 done_tmo;
  logic                 done_any;
  logic                 clr_f;
  logic                 clr_d;
  logic                 pick_data;

  // Completion / abort decode for the in-flight grant and the round-robin choice.
  always_comb begin
    done_ok   = (state == S_WAIT) &&
                (bus.mem_request_type ? bus.mem_write_complete : bus.mem_ready);
    done_tmo  = (state == S_WAIT) && !done_ok && (wd == WD_LAST);
    done_any  = done_ok || done_tmo;
    clr_f     = done_any && (owner == GRANT_FETCH);
    clr_d     = done_any && (owner == GRANT_DATA);
    pick_data = d_pend && (!f_pend || (last_grant == GRANT_FETCH));
  end

  assign bus.busy      = (state != S_IDLE) || f_pend || d_pend || s_pend;
  assign bus.state_dbg = state;

  // FSM, request latches and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= S_IDLE;
      wd                   <= '0;
      last_grant           <= GRANT_DATA;
      owner                <= GRANT_FETCH;
      f_pend               <= 1'b0;
      f_addr               <= '0;
      d_pend               <= 1'b0;
      d_we_q               <= 1'b0;
      d_addr_q             <= '0;
      d_wdata_q            <= '0;
      s_pend               <= 1'b0;
      bus.if_data          <= '0;
      bus.if_ready         <= 1'b0;
      bus.d_rdata          <= '0;
      bus.d_done           <= 1'b0;
      bus.mem_request      <= 1'b0;
      bus.mem_request_type <= 1'b0;
      bus.mem_address      <= '0;
      bus.mem_write_data   <= '0;
      bus.mem_special      <= 1'b0;
      bus.timeout_err      <= 1'b0;
    end else begin
      bus.mem_request <= 1'b0;
      bus.mem_special <= 1'b0;
      bus.if_ready    <= 1'b0;
      bus.d_done      <= 1'b0;
      bus.timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (f_pend || d_pend) begin
            state           <= S_ISSUE;
            bus.mem_request <= 1'b1;
            owner           <= pick_data;
            last_grant      <= pick_data;
            if (pick_data) begin
              bus.mem_request_type <= d_we_q;
              bus.mem_address      <= d_addr_q;
              bus.mem_write_data   <= d_wdata_q;
            end else begin
              bus.mem_request_type <= 1'b0;
              bus.mem_address      <= f_addr;
            end
          end else if (s_pend) begin
            bus.mem_special <= 1'b1;
            s_pend          <= 1'b0;
            state           <= S_STORE_GAP;
          end
        end
        S_ISSUE: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done_any) begin
            state           <= S_IDLE;
            bus.timeout_err <= done_tmo;
            if (owner == GRANT_DATA) begin
              d_pend     <= 1'b0;
              bus.d_done <= 1'b1;
              if (!bus.mem_request_type) begin
                bus.d_rdata <= done_tmo ? 16'hFFFF : bus.mem_data_out;
              end
            end else begin
              f_pend       <= 1'b0;
              bus.if_ready <= 1'b1;
              bus.if_data  <= done_tmo ? 16'hFFFF : bus.mem_data_out;
            end
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_STORE_GAP: state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase

      // New requests latch after the FSM so a set overrides a same-edge clear.
      if (bus.if_req && (!f_pend || clr_f)) begin
        f_pend <= 1'b1;
        f_addr <= bus.if_addr;
      end
      if (bus.d_req && (!d_pend || clr_d)) begin
        d_pend    <= 1'b1;
        d_we_q    <= bus.d_we;
        d_addr_q  <= bus.d_addr;
        d_wdata_q <= bus.d_wdata;
      end
      if (bus.store_req) begin
        s_pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// timestamp-based transaction model.
module tb_spi_mem_arbiter;
  localparam int TMO = 4000;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_grants = 0;

  spi_mem_arbiter_if bus ();

  spi_mem_arbiter #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  // Pending requests as seen in the current cycle.
  bit          m_fp, m_dp, m_sp, m_dwe, m_last;
  logic [15:0] m_faddr, m_daddr, m_dwdata;
  // In-flight transaction, described by the cycle its mem_request pulse occupies.
  bit          m_txn, m_owner, m_wr;
  int          m_issue;
  int          m_free;
  logic [15:0] m_addr, m_wdata;
  // Expected outputs for the current cycle.
  bit          e_req, e_spec, e_ifr, e_dd, e_to, e_busy;
  logic [15:0] e_ifd, e_drd;
  logic [16:0] exp_q[$];

  task automatic model_reset();
    m_fp = 0; m_dp = 0; m_sp = 0; m_dwe = 0; m_last = 1;
    m_faddr = '0; m_daddr = '0; m_dwdata = '0;
    m_txn = 0; m_owner = 0; m_wr = 0; m_issue = 0; m_free = 0;
    m_addr = '0; m_wdata = '0;
    e_req = 0; e_spec = 0; e_ifr = 0; e_dd = 0; e_to = 0; e_busy = 0;
    e_ifd = '0; e_drd = '0;
    exp_q.delete();
  endtask

  task automatic check_cycle();
    logic [16:0] g;
    chk("mem_request", bus.mem_request, e_req);
    chk("mem_special", bus.mem_special, e_spec);
    chk("if_ready", bus.if_ready, e_ifr);
    chk("d_done", bus.d_done, e_dd);
    chk("timeout_err", bus.timeout_err, e_to);
    chk("if_data", bus.if_data, e_ifd);
    chk("d_rdata", bus.d_rdata, e_drd);
    chk("busy", bus.busy, e_busy);
    if (m_txn) begin
      chk("mem_address_hold", bus.mem_address, m_addr);
      chk("mem_type_hold", bus.mem_request_type, m_wr);
      if (m_wr) chk("mem_wdata_hold", bus.mem_write_data, m_wdata);
    end
    if (bus.mem_request === 1'b1) begin
      chk("grant_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        g = exp_q.pop_front();
        chk("grant_order", {bus.mem_request_type, bus.mem_address}, g);
      end
    end
  endtask

  // Works out what the next cycle must show from this cycle's inputs.
  task automatic model_step();
    bit got;
    bit pick_d;
    int waited;
    bit clr_f, clr_d;
    e_req = 0; e_spec = 0; e_ifr = 0; e_dd = 0; e_to = 0;
    clr_f = 0; clr_d = 0;
    if (m_txn) begin
      if (cyc > m_issue) begin
        got    = m_wr ? bus.mem_write_complete : bus.mem_ready;
        waited = cyc - m_issue;
        if (got || waited == TMO) begin
          e_to = !got;
          if (m_owner) begin
            e_dd  = 1;
            clr_d = 1;
            if (!m_wr) e_drd = got ? bus.mem_data_out : 16'hFFFF;
          end else begin
            e_ifr = 1;
            clr_f = 1;
            e_ifd = got ? bus.mem_data_out : 16'hFFFF;
          end
          m_txn  = 0;
          m_free = cyc + 1;
        end
      end
    end else if (cyc >= m_free) begin
      if (m_fp || m_dp) begin
        pick_d  = m_dp && (!m_fp || !m_last);
        m_owner = pick_d;
        m_last  = pick_d;
        m_wr    = pick_d && m_dwe;
        m_addr  = pick_d ? m_daddr : m_faddr;
        m_wdata = m_dwdata;
        m_issue = cyc + 1;
        m_txn   = 1;
        e_req   = 1;
        exp_q.push_back({m_wr, m_addr});
      end else if (m_sp) begin
        e_spec = 1;
        m_sp   = 0;
        m_free = cyc + 2;
      end
    end
    if (clr_f) m_fp = 0;
    if (clr_d) m_dp = 0;
    if (bus.if_req && !m_fp) begin
      m_fp = 1; m_faddr = bus.if_addr;
    end
    if (bus.d_req && !m_dp) begin
      m_dp = 1; m_dwe = bus.d_we; m_daddr = bus.d_addr; m_dwdata = bus.d_wdata;
    end
    if (bus.store_req) m_sp = 1;
    e_busy = m_txn || (cyc + 1 < m_free) || m_fp || m_dp || m_sp;
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("reset_data", {bus.if_data, bus.d_rdata}, 32'h0);
        chk("reset_mem", {bus.mem_address, bus.mem_write_data}, 32'h0);
        chk("reset_strobes", {bus.if_ready, bus.d_done, bus.mem_request, bus.mem_request_type,
                              bus.mem_special, bus.busy, bus.timeout_err}, 32'h0);
        model_reset();
      end else begin
        check_cycle();
        model_step();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.if_req = 0; bus.d_req = 0; bus.store_req = 0;
    bus.mem_ready = 0; bus.mem_write_complete = 0;
  endtask

  task automatic do_reset();
    next_cycle(); reset = 1;
    next_cycle(); reset = 0;
  endtask

  function automatic bit sig_now(input int which);
    case (which)
      0:       return bus.mem_request;
      1:       return bus.if_ready;
      2:       return bus.d_done;
      3:       return bus.mem_special;
      default: return bus.if_ready | bus.d_done;
    endcase
  endfunction

  // Waits (bounded) for a DUT strobe; returns at the negedge of the cycle it is seen.
  task automatic wait_sig(input int which, input int budget, output bit seen, output int at);
    seen = 0;
    at   = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig_now(which)) begin
        seen = 1;
        at   = cyc;
        break;
      end
      next_cycle();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    bit seen;
    int at, t0, r_at;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.store_req = 0;
    bus.mem_data_out = '0; bus.mem_ready = 0; bus.mem_write_complete = 0;
    #1 reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // 1: single fetch, response 10 cycles after mem_request
    next_cycle(); bus.if_req = 1; bus.if_addr = 16'h0040; t0 = cyc;
    wait_sig(0, 6, seen, at);
    chk("t1_req_seen", seen, 1);
    chk("t1_req_latency", at - t0, 2);
    chk("t1_addr", bus.mem_address, 16'h0040);
    chk("t1_type", bus.mem_request_type, 0);
    repeat (10) next_cycle();
    bus.mem_ready = 1; bus.mem_data_out = 16'hBEEF; r_at = cyc;
    wait_sig(1, 4, seen, at);
    chk("t1_ready_seen", seen, 1);
    chk("t1_ready_latency", at - r_at, 1);
    chk("t1_if_data", bus.if_data, 16'hBEEF);
    next_cycle(); @(negedge clk);
    chk("t1_ready_pulse", bus.if_ready, 0);

    // 2: data write; a stray read strobe must be ignored
    next_cycle(); bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h1234; bus.d_wdata = 16'h00A5;
    wait_sig(0, 6, seen, at);
    chk("t2_req_seen", seen, 1);
    chk("t2_type", bus.mem_request_type, 1);
    chk("t2_addr", bus.mem_address, 16'h1234);
    chk("t2_wdata", bus.mem_write_data, 16'h00A5);
    repeat (3) next_cycle();
    bus.mem_ready = 1; bus.mem_data_out = 16'h1111;
    next_cycle(); bus.mem_write_complete = 1;
    wait_sig(2, 4, seen, at);
    chk("t2_done_seen", seen, 1);
    chk("t2_no_if_ready", bus.if_ready, 0);
    chk("t2_rdata_kept", bus.d_rdata, 16'h0000);

    // 3: simultaneous fetch+data, four times: grants alternate F,D starting with F
    do_reset();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      bus.if_req = 1; bus.if_addr = 16'h0100 + 16'(k);
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0200 + 16'(k);
      for (int j = 0; j < 2; j++) begin
        wait_sig(0, 8, seen, at);
        chk("t3_req_seen", seen, 1);
        chk("t3_grant_addr", bus.mem_address, (j == 1) ? (16'h0200 + 16'(k)) : (16'h0100 + 16'(k)));
        next_cycle(); next_cycle();
        bus.mem_ready = 1; bus.mem_data_out = 16'hC000 + 16'(2 * k + j);
        wait_sig((j == 1) ? 2 : 1, 4, seen, at);
        chk("t3_done_seen", seen, 1);
      end
    end

    // 4: store waits behind a pending fetch
    do_reset();
    next_cycle(); bus.if_req = 1; bus.if_addr = 16'h0050; bus.store_req = 1;
    wait_sig(0, 6, seen, at);
    chk("t4_req_seen", seen, 1);
    chk("t4_addr", bus.mem_address, 16'h0050);
    chk("t4_no_special_yet", bus.mem_special, 0);
    next_cycle(); next_cycle();
    bus.mem_ready = 1; bus.mem_data_out = 16'h5A5A;
    wait_sig(1, 4, seen, at);
    chk("t4_ready_seen", seen, 1);
    t0 = at;
    wait_sig(3, 4, seen, at);
    chk("t4_special_seen", seen, 1);
    chk("t4_special_after_ready", at - t0, 1);
    chk("t4_busy_gap", bus.busy, 1);
    next_cycle(); @(negedge clk);
    chk("t4_busy_drop", bus.busy, 0);
    chk("t4_special_once", bus.mem_special, 0);

    // 5: data read with no response -> watchdog abort
    do_reset();
    next_cycle(); bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0300;
    wait_sig(0, 6, seen, at);
    chk("t5_req_seen", seen, 1);
    t0 = at;
    wait_sig(2, TMO + 10, seen, at);
    chk("t5_done_seen", seen, 1);
    chk("t5_timeout_latency", at - t0, TMO + 1);
    chk("t5_timeout_err", bus.timeout_err, 1);
    chk("t5_rdata", bus.d_rdata, 16'hFFFF);
    chk("t5_idle", bus.busy, 0);

    // 6: reset during WAIT; a later mem_ready produces nothing
    do_reset();
    next_cycle(); bus.if_req = 1; bus.if_addr = 16'h0060;
    wait_sig(0, 6, seen, at);
    chk("t6_req_seen", seen, 1);
    repeat (3) next_cycle();
    reset = 1;
    @(negedge clk);
    chk("t6_strobes_zero", {bus.mem_request, bus.mem_request_type, bus.busy, bus.if_ready,
                            bus.d_done, bus.mem_special, bus.timeout_err}, 32'h0);
    chk("t6_addr_zero", bus.mem_address, 16'h0000);
    next_cycle(); reset = 0;
    next_cycle(); bus.mem_ready = 1; bus.mem_data_out = 16'h7777;
    wait_sig(1, 10, seen, at);
    chk("t6_no_strobe", seen, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if (bus.mem_request === 1'b1) n_grants++;
      bus.if_req             = ($urandom_range(3) == 0);
      bus.if_addr            = 16'($urandom);
      bus.d_req              = ($urandom_range(3) == 0);
      bus.d_we               = 1'($urandom_range(1));
      bus.d_addr             = 16'($urandom);
      bus.d_wdata            = 16'($urandom);
      bus.store_req          = ($urandom_range(15) == 0);
      bus.mem_ready          = ($urandom_range(5) == 0);
      bus.mem_write_complete = ($urandom_range(5) == 0);
      bus.mem_data_out       = 16'($urandom);
    end
    chk("rand_activity", n_grants > 50, 1);
    repeat (5) next_cycle();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
